dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words held.
REQ-002 SHALL have parameter LATENCY, default 2, wait cycles before response, legal 0..15.
REQ-003 SHALL have port clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  memory stage presents access.
REQ-006 SHALL have port req_write  input  1  1 = store (mem_write), 0 = load.
REQ-007 SHALL have port req_addr  input  32  byte address (alu_result).
REQ-008 SHALL have port req_wdata  input  32  store data (write_data).
REQ-009 SHALL have port flush  input  1  memory-stage flush from hazard logic.
REQ-010 SHALL have port req_ready  output  1  request acceptable this cycle.
REQ-011 SHALL have port resp_valid  output  1  one-cycle response strobe.
REQ-012 SHALL have port resp_rdata  output  32  load data, valid with resp_valid.
REQ-013 SHALL have port resp_err  output  1  access fault, valid with resp_valid.
REQ-014 SHALL have port stall  output  1  memory-stage stall request to hazard logic.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP.
REQ-016 SHALL drive req_ready=1 only in IDLE.
REQ-017 SHALL accept on req_valid && req_ready && !flush, capturing write, addr, wdata into internal registers.
REQ-018 On acceptance, SHALL load the counter with LATENCY and go to WAIT, or straight to RESP when LATENCY=0.
REQ-019 In WAIT, SHALL decrement the counter each cycle and go to RESP on the cycle the counter reads 1.
REQ-020 Timing: acceptance in cycle N gives resp_valid=1 in exactly cycle N+LATENCY+1, for one cycle only.
REQ-021 SHALL return from RESP to IDLE unconditionally after one cycle.
REQ-022 SHALL drive stall = (IDLE && req_valid && !flush) || WAIT, and stall=0 in RESP so the pipeline advances on the response cycle.
REQ-023 SHALL fault when addr[1:0] != 0 or addr[31:2] >= DEPTH.
REQ-024 On fault: resp_err=1, resp_rdata=0, memory unchanged.
REQ-025 Load without fault: resp_rdata = mem[addr[31:2]] as sampled in the RESP cycle.
REQ-026 Store without fault: SHALL write mem[addr[31:2]] at the end of the RESP cycle; resp_rdata=0.
REQ-027 Outside RESP, resp_rdata and resp_err SHALL be 0.
REQ-028 flush in WAIT SHALL abort: next state IDLE, no response, no write.
REQ-029 flush in the RESP cycle SHALL suppress resp_valid and the write.
REQ-030 flush in IDLE SHALL block acceptance that cycle.
REQ-031 A load accepted after a completed store to the same address SHALL return the stored value.
REQ-032 req_valid held high through RESP SHALL NOT cause a second acceptance, because req_ready=0 in RESP.
REQ-033 Counter width SHALL be 4 bits; wrap-around SHALL never occur for legal LATENCY.

Reset
REQ-034 Assertion of reset SHALL immediately, without waiting for a clock edge, set state=IDLE, counter=0, resp_valid=0, resp_rdata=0, resp_err=0, and all captured registers to 0.
REQ-035 Reset SHALL clear all DEPTH memory words to 0.
REQ-036 Reset mid-WAIT or mid-RESP SHALL abandon the access with no write and no response.
REQ-037 After reset deassertion: req_ready=1; stall equals req_valid (combinational per REQ-022).

Verification
REQ-038 Reset, no request -> req_ready=1, stall=0, resp_valid=0; load of 0x0 returns 0x00000000.
REQ-039 LATENCY=2, store 0xDEADBEEF to 0x10 accepted in cycle 0 -> stall=1 cycles 0-2, resp_valid=1 in cycle 3 with stall=0; following load of 0x10 -> resp_rdata=0xDEADBEEF in its N+3 cycle.
REQ-040 Store 0x12345678 to 0x13 (misaligned), then to 0x100 (DEPTH=64) -> resp_err=1 each time, resp_rdata=0; load of 0x10 still returns 0xDEADBEEF.
REQ-041 Store 0xCAFEF00D to 0x20, flush asserted one cycle into WAIT -> no resp_valid, FSM in IDLE next cycle; load of 0x20 returns 0x00000000.
REQ-042 LATENCY=0, back-to-back loads held on req_valid -> resp_valid every second cycle, never two consecutive cycles, no double acceptance.
REQ-043 Store 0xDEADBEEF to 0x10 completed, reset pulsed during a later load's WAIT -> resp_valid never asserts; load of 0x10 returns 0x00000000.

Source files
------------

// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline memory stage.
// Accepts one load/store at a time, waits LATENCY cycles, then responds for one cycle.
// An access faults if it is misaligned or beyond DEPTH words. Hazard logic may flush it.
module dmem_responder #(
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        stall
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] mem_q [DEPTH];

  logic            accept;
  logic            fault;
  logic            commit;
  logic [IdxW-1:0] idx;

  assign accept = req_valid && (state_q == StIdle) && !flush;
  assign idx    = addr_q[IdxW+1:2];
  assign fault  = (addr_q[1:0] != 2'b00) || ({2'b00, addr_q[31:2]} >= 32'(DEPTH));
  // The response (and any store) only takes effect if the RESP cycle is not flushed.
  assign commit = (state_q == StResp) && !flush;

  // State and wait counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d   = 4'(LATENCY);
          state_d = (LATENCY == 0) ? StResp : StWait;
        end
      end
      StWait: begin
        if (flush) begin
          state_d = StIdle;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = StResp;
        end
      end
      StResp: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs; data and error are forced to zero whenever no response is presented.
  always_comb begin
    req_ready  = (state_q == StIdle);
    stall      = ((state_q == StIdle) && req_valid && !flush) || (state_q == StWait);
    resp_valid = commit;
    resp_err   = commit && fault;
    resp_rdata = 32'd0;
    if (commit && !fault && !write_q) resp_rdata = mem_q[idx];
  end

  // Capture the accepted request.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else if (accept) begin
      write_q <= req_write;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Word storage; a store lands at the end of an unflushed, fault-free RESP cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 32'd0;
    end else if (commit && write_q && !fault) begin
      mem_q[idx] <= wdata_q;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance and a LATENCY=0 instance.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset;

  logic        a_req_valid, a_req_write, a_flush;
  logic [31:0] a_req_addr, a_req_wdata;
  logic        a_req_ready, a_resp_valid, a_resp_err, a_stall;
  logic [31:0] a_resp_rdata;

  logic        z_req_valid, z_req_write, z_flush;
  logic [31:0] z_req_addr, z_req_wdata;
  logic        z_req_ready, z_resp_valid, z_resp_err, z_stall;
  logic [31:0] z_resp_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(64), .LATENCY(2)) dut_a (
    .clk       (clk),
    .reset     (reset),
    .req_valid (a_req_valid),
    .req_write (a_req_write),
    .req_addr  (a_req_addr),
    .req_wdata (a_req_wdata),
    .flush     (a_flush),
    .req_ready (a_req_ready),
    .resp_valid(a_resp_valid),
    .resp_rdata(a_resp_rdata),
    .resp_err  (a_resp_err),
    .stall     (a_stall)
  );

  dmem_responder #(.DEPTH(64), .LATENCY(0)) dut_z (
    .clk       (clk),
    .reset     (reset),
    .req_valid (z_req_valid),
    .req_write (z_req_write),
    .req_addr  (z_req_addr),
    .req_wdata (z_req_wdata),
    .flush     (z_flush),
    .req_ready (z_req_ready),
    .resp_valid(z_resp_valid),
    .resp_rdata(z_resp_rdata),
    .resp_err  (z_resp_err),
    .stall     (z_stall)
  );

  // Issue one access on dut_a in the current cycle and observe the first response.
  task automatic run_access(input logic w, input logic [31:0] addr, input logic [31:0] wdata,
                            output int vcyc, output logic [31:0] rdata, output logic err,
                            output int nvalid);
    a_req_valid = 1'b1;
    a_req_write = w;
    a_req_addr  = addr;
    a_req_wdata = wdata;
    vcyc = -1; rdata = 32'd0; err = 1'b0; nvalid = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (a_resp_valid) begin
        nvalid++;
        if (vcyc < 0) begin
          vcyc = k; rdata = a_resp_rdata; err = a_resp_err;
        end
      end
      @(posedge clk); #1;
      if (k == 0) begin
        a_req_valid = 1'b0;
        a_req_write = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    int vcyc, nvalid;
    logic [31:0] rdata;
    logic err;
    #1;
    checks++;
    if (a_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", a_req_ready); end
    checks++;
    if (a_resp_valid !== 1'b0 || a_stall !== 1'b0) begin
      errors++; $display("FAIL reset_idle got valid=%b stall=%b exp 0 0", a_resp_valid, a_stall);
    end
    checks++;
    if (a_resp_rdata !== 32'd0 || a_resp_err !== 1'b0) begin
      errors++; $display("FAIL reset_resp got %h/%b exp 0/0", a_resp_rdata, a_resp_err);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    a_req_valid = 1'b1;
    #1;
    checks++;
    if (a_stall !== 1'b1) begin errors++; $display("FAIL stall_comb got %b exp 1", a_stall); end
    a_req_valid = 1'b0;
    @(posedge clk); #1;
    run_access(1'b0, 32'h0, 32'h0, vcyc, rdata, err, nvalid);
    checks++;
    if (vcyc !== 3 || rdata !== 32'd0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_load0 got cyc=%0d data=%h err=%b exp 3 0 0", vcyc, rdata, err);
    end
  endtask

  task automatic test_store_load();
    int vcyc, nvalid;
    logic [31:0] rdata;
    logic err;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h10; a_req_wdata = 32'hDEADBEEF;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (a_stall !== (k < 3) || a_resp_valid !== (k == 3)) begin
        errors++;
        $display("FAIL store_timing c%0d got stall=%b valid=%b exp %b %b", k, a_stall,
                 a_resp_valid, (k < 3), (k == 3));
      end
      if (k == 3) begin
        checks++;
        if (a_resp_rdata !== 32'd0 || a_resp_err !== 1'b0) begin
          errors++; $display("FAIL store_resp got %h/%b exp 0/0", a_resp_rdata, a_resp_err);
        end
      end
      @(posedge clk); #1;
      if (k == 0) begin a_req_valid = 1'b0; a_req_write = 1'b0; end
    end
    run_access(1'b0, 32'h10, 32'h0, vcyc, rdata, err, nvalid);
    checks++;
    if (vcyc !== 3 || rdata !== 32'hDEADBEEF || nvalid !== 1) begin
      errors++; $display("FAIL load_10 got cyc=%0d data=%h n=%0d exp 3 deadbeef 1", vcyc, rdata, nvalid);
    end
  endtask

  task automatic test_fault();
    int vcyc, nvalid;
    logic [31:0] rdata;
    logic err;
    run_access(1'b1, 32'h13, 32'h12345678, vcyc, rdata, err, nvalid);
    checks++;
    if (vcyc !== 3 || err !== 1'b1 || rdata !== 32'd0) begin
      errors++; $display("FAIL fault_misaligned got cyc=%0d err=%b data=%h exp 3 1 0", vcyc, err, rdata);
    end
    run_access(1'b1, 32'h100, 32'h12345678, vcyc, rdata, err, nvalid);
    checks++;
    if (vcyc !== 3 || err !== 1'b1 || rdata !== 32'd0) begin
      errors++; $display("FAIL fault_range got cyc=%0d err=%b data=%h exp 3 1 0", vcyc, err, rdata);
    end
    run_access(1'b0, 32'h10, 32'h0, vcyc, rdata, err, nvalid);
    checks++;
    if (rdata !== 32'hDEADBEEF || err !== 1'b0) begin
      errors++; $display("FAIL fault_nowrite got %h/%b exp deadbeef/0", rdata, err);
    end
    // Highest legal word must not fault.
    run_access(1'b1, 32'hFC, 32'hA5A5A5A5, vcyc, rdata, err, nvalid);
    run_access(1'b0, 32'hFC, 32'h0, vcyc, rdata, err, nvalid);
    checks++;
    if (rdata !== 32'hA5A5A5A5 || err !== 1'b0) begin
      errors++; $display("FAIL top_word got %h/%b exp a5a5a5a5/0", rdata, err);
    end
  endtask

  task automatic test_flush_wait();
    int vcyc, nvalid, seen;
    logic [31:0] rdata;
    logic err;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (a_stall !== 1'b1) begin errors++; $display("FAIL flush_wait_stall got %b exp 1", a_stall); end
    @(posedge clk); #1;
    a_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1 || a_stall !== 1'b0) begin
      errors++; $display("FAIL flush_wait_idle got ready=%b stall=%b exp 1 0", a_req_ready, a_stall);
    end
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      if (a_resp_valid) seen++;
      @(negedge clk);
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL flush_wait_noresp got %0d exp 0", seen); end
    @(posedge clk); #1;
    run_access(1'b0, 32'h20, 32'h0, vcyc, rdata, err, nvalid);
    checks++;
    if (rdata !== 32'd0 || vcyc !== 3) begin
      errors++; $display("FAIL flush_wait_nowrite got %h cyc=%0d exp 0 3", rdata, vcyc);
    end
  endtask

  task automatic test_flush_resp();
    int vcyc, nvalid;
    logic [31:0] rdata;
    logic err;
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h24; a_req_wdata = 32'h11112222;
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_req_write = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (a_resp_valid !== 1'b0 || a_stall !== 1'b0) begin
      errors++; $display("FAIL flush_resp got valid=%b stall=%b exp 0 0", a_resp_valid, a_stall);
    end
    @(posedge clk); #1;
    a_flush = 1'b0;
    run_access(1'b0, 32'h24, 32'h0, vcyc, rdata, err, nvalid);
    checks++;
    if (rdata !== 32'd0) begin errors++; $display("FAIL flush_resp_nowrite got %h exp 0", rdata); end
  endtask

  task automatic test_flush_idle();
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h0; a_flush = 1'b1;
    @(negedge clk);
    checks++;
    if (a_stall !== 1'b0 || a_req_ready !== 1'b1) begin
      errors++; $display("FAIL flush_idle got stall=%b ready=%b exp 0 1", a_stall, a_req_ready);
    end
    @(posedge clk); #1;
    a_req_valid = 1'b0; a_flush = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req_ready !== 1'b1) begin errors++; $display("FAIL flush_idle_block got %b exp 1", a_req_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int nresp;
    z_req_valid = 1'b1; z_req_write = 1'b1; z_req_addr = 32'h8; z_req_wdata = 32'h55AA55AA;
    @(posedge clk); #1;
    z_req_valid = 1'b0; z_req_write = 1'b0;
    @(negedge clk);
    checks++;
    if (z_resp_valid !== 1'b1 || z_stall !== 1'b0) begin
      errors++; $display("FAIL lat0_store got valid=%b stall=%b exp 1 0", z_resp_valid, z_stall);
    end
    @(posedge clk); #1;
    z_req_valid = 1'b1; z_req_addr = 32'h8;
    nresp = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (z_resp_valid) nresp++;
      checks++;
      if (z_resp_valid !== (k % 2 == 1) || z_req_ready !== (k % 2 == 0)) begin
        errors++;
        $display("FAIL lat0_b2b c%0d got valid=%b ready=%b exp %b %b", k, z_resp_valid,
                 z_req_ready, (k % 2 == 1), (k % 2 == 0));
      end
      if (k % 2 == 1) begin
        checks++;
        if (z_resp_rdata !== 32'h55AA55AA) begin
          errors++; $display("FAIL lat0_data c%0d got %h exp 55aa55aa", k, z_resp_rdata);
        end
      end
      @(posedge clk); #1;
    end
    z_req_valid = 1'b0;
    checks++;
    if (nresp !== 5) begin errors++; $display("FAIL lat0_count got %0d exp 5", nresp); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid_wait();
    int vcyc, nvalid, seen;
    logic [31:0] rdata;
    logic err;
    a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h10;
    @(posedge clk); #1;
    a_req_valid = 1'b0;
    #1 reset = 1'b1;
    #1;
    checks++;
    if (a_req_ready !== 1'b1 || a_stall !== 1'b0 || a_resp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_async got ready=%b stall=%b valid=%b exp 1 0 0", a_req_ready,
                         a_stall, a_resp_valid);
    end
    #1 reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (a_resp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_noresp got %0d exp 0", seen); end
    @(posedge clk); #1;
    run_access(1'b0, 32'h10, 32'h0, vcyc, rdata, err, nvalid);
    checks++;
    if (rdata !== 32'd0 || vcyc !== 3) begin
      errors++; $display("FAIL reset_cleared got %h cyc=%0d exp 0 3", rdata, vcyc);
    end
  endtask

  initial begin
    reset = 1'b1;
    a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = 32'h0; a_req_wdata = 32'h0; a_flush = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 32'h0; z_req_wdata = 32'h0; z_flush = 1'b0;
    test_reset();
    test_store_load();
    test_fault();
    test_flush_wait();
    test_flush_resp();
    test_flush_idle();
    test_back_to_back();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
